// File: rtl/stepper_step_scheduler.sv
// rtl/stepper_step_scheduler.sv - DDA scheduler spreading per-tick microstep deltas into STEP/DIR pulses
// Optional feature macro: STEPPER_IDLE_DISABLE_EN (drop driver_en after IDLE_TICKS zero-delta ticks)
module stepper_step_scheduler #(
  parameter int SIM_PERIOD       = 500000,
  parameter int PULSE_CYCLES     = 100,
  parameter int DIR_SETUP_CYCLES = 50,
  parameter int STEPS_PER_REV    = 3200
`ifdef STEPPER_IDLE_DISABLE_EN
  ,
  parameter int IDLE_TICKS       = 200
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sim_tick,
  input  logic signed [15:0] delta_steps,
  input  logic               status_clear,
  output logic               step,
  output logic               dir,
  output logic               driver_en,
  output logic               busy,
  output logic               overrun,
  output logic               saturated,
  output logic [15:0]        motor_pos
);
  // The clamp keeps request spacing at or above one full pulse period.
  localparam int MAX_STEPS = SIM_PERIOD / (2 * PULSE_CYCLES);
  localparam int AW = $clog2(SIM_PERIOD + 1) + 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int SW = $clog2(DIR_SETUP_CYCLES + 1);
  localparam logic [16:0]   MAX_MAG    = 17'(MAX_STEPS);
  localparam logic [AW-1:0] PERIOD     = AW'(SIM_PERIOD);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(DIR_SETUP_CYCLES - 1);
  localparam logic [15:0]   POS_LAST   = 16'(STEPS_PER_REV - 1);
`ifdef STEPPER_IDLE_DISABLE_EN
  localparam bit WAKE_SETUP = 1'b1;
`else
  localparam bit WAKE_SETUP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIR_SETUP, RUN} state_t;
  state_t state, state_nxt;

  logic               tick_cur, tick_prev, tick_evt;
  logic signed [15:0] delta_q;
  logic [16:0]        mag_raw, mag_new, pending;
  logic [AW-1:0]      mag, acc, acc_sum;
  logic               new_dir, clamp;
  logic [SW-1:0]      setup_cnt;
  logic [PW-1:0]      pulse_cnt;
  logic               pulse_low, pulse_ready, pulse_idle, step_req;

  assign tick_evt    = tick_cur & ~tick_prev;
  assign mag_raw     = delta_q[15] ? (17'd0 - {delta_q[15], delta_q}) : {1'b0, delta_q};
  assign clamp       = mag_raw > MAX_MAG;
  assign mag_new     = clamp ? MAX_MAG : mag_raw;
  assign new_dir     = ~delta_q[15];
  assign acc_sum     = acc + mag;
  assign pulse_idle  = ~step & ~pulse_low;
  assign pulse_ready = ~step & (~pulse_low | (pulse_cnt == PULSE_LAST));
  assign step_req    = (state == RUN) && !tick_evt && (pending != 17'd0) && (acc_sum >= PERIOD);
  assign busy        = (state != IDLE);

  // Register sim_tick and delta together so the edge and its delta are seen in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cur  <= 1'b0;
      tick_prev <= 1'b0;
      delta_q   <= '0;
    end else begin
      tick_cur  <= sim_tick;
      tick_prev <= tick_cur;
      delta_q   <= delta_steps;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a new tick always restarts scheduling, abandoning any unfinished steps.
  always_comb begin
    state_nxt = state;
    if (tick_evt) begin
      if (mag_new == 17'd0)                      state_nxt = IDLE;
      else if ((new_dir != dir) || WAKE_SETUP)   state_nxt = DIR_SETUP;
      else                                       state_nxt = RUN;
    end else begin
      case (state)
        DIR_SETUP: if (setup_cnt == SETUP_LAST) state_nxt = RUN;
        RUN:       if ((pending == 17'd0) && pulse_idle) state_nxt = IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  // Latch the new delta on a tick and advance the DDA accumulator while running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mag       <= '0;
      acc       <= '0;
      pending   <= '0;
      setup_cnt <= '0;
      dir       <= 1'b1;
    end else if (tick_evt) begin
      mag       <= AW'(mag_new);
      acc       <= '0;
      pending   <= mag_new;
      setup_cnt <= '0;
      if (mag_new != 17'd0) dir <= new_dir;
    end else begin
      if (state == DIR_SETUP) setup_cnt <= setup_cnt + SW'(1);
      if (state == RUN) acc <= (acc_sum >= PERIOD) ? (acc_sum - PERIOD) : acc_sum;
      if (step_req) pending <= pending - 17'd1;
    end
  end

  // Pulse generator: PULSE_CYCLES high then at least PULSE_CYCLES low per request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step      <= 1'b0;
      pulse_low <= 1'b0;
      pulse_cnt <= '0;
    end else if (step_req) begin
      assert (pulse_ready);
      step      <= 1'b1;
      pulse_low <= 1'b0;
      pulse_cnt <= '0;
    end else if (step) begin
      if (pulse_cnt == PULSE_LAST) begin
        step      <= 1'b0;
        pulse_low <= 1'b1;
        pulse_cnt <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + PW'(1);
      end
    end else if (pulse_low) begin
      if (pulse_cnt == PULSE_LAST) pulse_low <= 1'b0;
      else                         pulse_cnt <= pulse_cnt + PW'(1);
    end
  end

  // Track commanded position on each STEP rising edge, wrapping within one revolution.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      motor_pos <= '0;
    end else if (step_req) begin
      if (dir) motor_pos <= (motor_pos == POS_LAST) ? 16'd0 : motor_pos + 16'd1;
      else     motor_pos <= (motor_pos == 16'd0) ? POS_LAST : motor_pos - 16'd1;
    end
  end

  // Sticky status flags; a setting event beats a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      saturated <= 1'b0;
    end else begin
      if (tick_evt && busy) overrun <= 1'b1;
      else if (status_clear) overrun <= 1'b0;
      if (tick_evt && clamp) saturated <= 1'b1;
      else if (status_clear) saturated <= 1'b0;
    end
  end

`ifdef STEPPER_IDLE_DISABLE_EN
  localparam int IW = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TICKS - 1);
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic          idle_off, idle_off_nxt;

  // Count consecutive zero-delta ticks seen in IDLE; any nonzero tick wakes the driver.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    idle_off_nxt = idle_off;
    if (tick_evt && (mag_new != 17'd0)) begin
      idle_cnt_nxt = '0;
      idle_off_nxt = 1'b0;
    end else if (tick_evt && (state == IDLE) && !idle_off) begin
      if (idle_cnt == IDLE_LAST) idle_off_nxt = 1'b1;
      else                       idle_cnt_nxt = idle_cnt + IW'(1);
    end
  end

  // Driver enable follows the idle-disable state once out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt  <= '0;
      idle_off  <= 1'b0;
      driver_en <= 1'b0;
    end else begin
      idle_cnt  <= idle_cnt_nxt;
      idle_off  <= idle_off_nxt;
      driver_en <= ~idle_off_nxt;
    end
  end
`else
  // Driver enable rises on the first clock after reset release and stays high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) driver_en <= 1'b0;
    else       driver_en <= 1'b1;
  end
`endif

endmodule
